// File: rtl/bank_rsp_arbiter_if.sv
// bank_rsp_arbiter_if: bank-side response requests and per-channel response slots of bank_rsp_arbiter.
// BANK_RSP_ARB_PERF_EN adds the per-channel grant/stall counter outputs.
interface bank_rsp_arbiter_if #(parameter int NUM_BANK = 4);
  localparam int BID_W = $clog2(NUM_BANK);
  logic [NUM_BANK-1:0] bank_valid_i, bank_ready_o;
  logic [2*NUM_BANK-1:0] bank_channel_id_i;
  logic [3*NUM_BANK-1:0] bank_rob_num_i;
  logic [128*NUM_BANK-1:0] bank_data_i;
  logic [2:0] ch_valid_o, ch_ready_i;
  logic [3*BID_W-1:0] ch_bank_id_o;
  logic [8:0] ch_rob_num_o;
  logic [383:0] ch_data_o;
  logic err_illegal_ch_o;
`ifdef BANK_RSP_ARB_PERF_EN
  logic [47:0] perf_grant_cnt_o, perf_stall_cnt_o;
  modport master (
    input bank_valid_i, bank_channel_id_i, bank_rob_num_i, bank_data_i, ch_ready_i,
    output bank_ready_o, ch_valid_o, ch_bank_id_o, ch_rob_num_o, ch_data_o, err_illegal_ch_o,
    output perf_grant_cnt_o, perf_stall_cnt_o
  );
  modport slave (
    output bank_valid_i, bank_channel_id_i, bank_rob_num_i, bank_data_i, ch_ready_i,
    input bank_ready_o, ch_valid_o, ch_bank_id_o, ch_rob_num_o, ch_data_o, err_illegal_ch_o,
    input perf_grant_cnt_o, perf_stall_cnt_o
  );
`else
  modport master (
    input bank_valid_i, bank_channel_id_i, bank_rob_num_i, bank_data_i, ch_ready_i,
    output bank_ready_o, ch_valid_o, ch_bank_id_o, ch_rob_num_o, ch_data_o, err_illegal_ch_o
  );
  modport slave (
    output bank_valid_i, bank_channel_id_i, bank_rob_num_i, bank_data_i, ch_ready_i,
    input bank_ready_o, ch_valid_o, ch_bank_id_o, ch_rob_num_o, ch_data_o, err_illegal_ch_o
  );
`endif
endinterface

// File: rtl/bank_rsp_arbiter.sv
// bank_rsp_arbiter: per-channel round-robin arbitration of bank read responses onto three registered response slots.
// Define BANK_RSP_ARB_PERF_EN for saturating per-channel grant and stall counters.
module bank_rsp_arbiter #(
  parameter int NUM_BANK = 4,
  localparam int BID_W = $clog2(NUM_BANK)
) (
  input logic clk_i,
  input logic rst_i,
  bank_rsp_arbiter_if.master bus
);
  function automatic logic [BID_W-1:0] wrap(input int i);
    return BID_W'(i % NUM_BANK);
  endfunction
  logic [2:0][BID_W-1:0] rr_ptr, gnt_bank, bank_id_q;
  logic [2:0][NUM_BANK-1:0] req;
  logic [2:0][2:0] rob_q;
  logic [2:0][127:0] data_q;
  logic [2:0] valid_q, free, gnt;
  logic [NUM_BANK-1:0] ready;
  logic err_q, illegal;
  always_comb begin
    free = ~valid_q | bus.ch_ready_i;
    req = '0;
    gnt = '0;
    gnt_bank = '0;
    ready = '0;
    illegal = 1'b0;
    for (int b = 0; b < NUM_BANK; b++) begin
      for (int c = 0; c < 3; c++)
        req[c][b] = bus.bank_valid_i[b] && bus.bank_channel_id_i[2*b +: 2] == 2'(c);
      illegal = illegal || (bus.bank_valid_i[b] && bus.bank_channel_id_i[2*b +: 2] == 2'd3);
    end
    // Scan from the far end back toward rr_ptr so the nearest requester is written last.
    for (int c = 0; c < 3; c++)
      for (int k = NUM_BANK - 1; k >= 0; k--)
        if (free[c] && req[c][wrap(int'(rr_ptr[c]) + k)]) begin
          gnt[c] = 1'b1;
          gnt_bank[c] = wrap(int'(rr_ptr[c]) + k);
        end
    for (int c = 0; c < 3; c++)
      if (gnt[c]) ready[gnt_bank[c]] = 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      valid_q <= '0;
      bank_id_q <= '0;
      rob_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | illegal;
      for (int c = 0; c < 3; c++)
        if (gnt[c]) begin
          rr_ptr[c] <= wrap(int'(gnt_bank[c]) + 1);
          valid_q[c] <= 1'b1;
          bank_id_q[c] <= gnt_bank[c];
          rob_q[c] <= bus.bank_rob_num_i[3*gnt_bank[c] +: 3];
          data_q[c] <= bus.bank_data_i[128*gnt_bank[c] +: 128];
        end else if (bus.ch_ready_i[c]) valid_q[c] <= 1'b0;
    end
  end
  assign bus.bank_ready_o = rst_i ? '0 : ready;
  assign bus.ch_valid_o = valid_q;
  assign bus.ch_bank_id_o = bank_id_q;
  assign bus.ch_rob_num_o = rob_q;
  assign bus.ch_data_o = data_q;
  assign bus.err_illegal_ch_o = err_q;
`ifdef BANK_RSP_ARB_PERF_EN
  logic [2:0][15:0] grant_cnt, stall_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else
      for (int c = 0; c < 3; c++) begin
        if (gnt[c] && grant_cnt[c] != 16'hFFFF) grant_cnt[c] <= grant_cnt[c] + 16'd1;
        if (valid_q[c] && !bus.ch_ready_i[c] && stall_cnt[c] != 16'hFFFF) stall_cnt[c] <= stall_cnt[c] + 16'd1;
      end
  end
  assign bus.perf_grant_cnt_o = grant_cnt;
  assign bus.perf_stall_cnt_o = stall_cnt;
`else
`endif
endmodule
